serial_adder_arbiter: RTL and testbench

SERIAL_ADDER_ARBITER -- requirements
Module: serial_adder_arbiter

---
 rtl/serial_adder_arbiter.sv | 153 +++++++++++++++
 tb/tb_serial_adder_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share a single serial adder.
// One transaction is in flight at a time: IDLE picks a winner, ISSUE grants it
// and starts the adder, WAIT collects the sum (or gives up after TIMEOUT cycles)
// and RESP returns the result to the owner.
module serial_adder_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH:0]          rsp_sum,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    add_start,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic                    add_done,
    input  logic [WIDTH:0]          add_sum
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NREQ-1:0] ONE_HOT_BASE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     lastOwner_q;
    logic [TW-1:0]     timer_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rspValid_q;
    logic [WIDTH:0]    rspSum_q;
    logic              rspErr_q;
    logic              busy_q;
    logic              addStart_q;
    logic [WIDTH-1:0]  addA_q;
    logic [WIDTH-1:0]  addB_q;

    logic              found_d;
    logic [IW-1:0]     winner_d;
    logic [WIDTH-1:0]  selA_d;
    logic [WIDTH-1:0]  selB_d;

    // Round-robin pick: first requesting index above the previous owner,
    // wrapping around, together with that requester's operands.
    always_comb begin
        int idx;
        idx      = 0;
        found_d  = 1'b0;
        winner_d = '0;
        selA_d   = '0;
        selB_d   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(lastOwner_q) + k) % NREQ;
            if (!found_d && req[idx]) begin
                found_d  = 1'b1;
                winner_d = IW'(idx);
                selA_d   = req_a[idx*WIDTH +: WIDTH];
                selB_d   = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Transaction sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= IW'(NREQ-1);
            timer_q     <= '0;
            gnt_q       <= '0;
            rspValid_q  <= '0;
            rspSum_q    <= '0;
            rspErr_q    <= 1'b0;
            busy_q      <= 1'b0;
            addStart_q  <= 1'b0;
            addA_q      <= '0;
            addB_q      <= '0;
        end else begin
            gnt_q      <= '0;
            rspValid_q <= '0;
            addStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q    <= ISSUE;
                        owner_q    <= winner_d;
                        addA_q     <= selA_d;
                        addB_q     <= selB_d;
                        gnt_q      <= ONE_HOT_BASE << winner_d;
                        addStart_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    timer_q <= '0;
                end
                WAIT: begin
                    if (add_done) begin
                        state_q    <= RESP;
                        rspSum_q   <= add_sum;
                        rspErr_q   <= 1'b0;
                        rspValid_q <= ONE_HOT_BASE << owner_q;
                        addA_q     <= '0;
                        addB_q     <= '0;
                    end else if (timer_q == TW'(TIMEOUT-1)) begin
                        state_q    <= RESP;
                        rspSum_q   <= '0;
                        rspErr_q   <= 1'b1;
                        rspValid_q <= ONE_HOT_BASE << owner_q;
                        addA_q     <= '0;
                        addB_q     <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    lastOwner_q <= owner_q;
                    busy_q      <= 1'b0;
                    rspSum_q    <= '0;
                    rspErr_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rspValid_q;
    assign rsp_sum   = rspSum_q;
    assign rsp_err   = rspErr_q;
    assign busy      = busy_q;
    assign add_start = addStart_q;
    assign add_a     = addA_q;
    assign add_b     = addB_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: requesters and the shared adder are modelled
// here; expected grants and responses come from a round-robin reference model.
module tb_serial_adder_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int T = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   reqA = '0;
    logic [N*W-1:0]   reqB = '0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rspValid;
    logic [W:0]       rspSum;
    logic             rspErr;
    logic             busy;
    logic             addStart;
    logic [W-1:0]     addA;
    logic [W-1:0]     addB;
    logic             addDone = 1'b0;
    logic [W:0]       addSum = '0;

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0] sum;
        bit         err;
        int         lat;
    } exp_t;

    exp_t gntQ[$];
    exp_t rspQ[$];
    int   delayQ[$];

    int nChecks   = 0;
    int nFails    = 0;
    int cyc       = 0;
    int lastOwner = N-1;
    int startCyc  = 0;
    bit inFlight  = 1'b0;

    serial_adder_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (reqA),
        .req_b     (reqB),
        .gnt       (gnt),
        .rsp_valid (rspValid),
        .rsp_sum   (rspSum),
        .rsp_err   (rspErr),
        .busy      (busy),
        .add_start (addStart),
        .add_a     (addA),
        .add_b     (addB),
        .add_done  (addDone),
        .add_sum   (addSum)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Any reset drop ends whatever transaction was in flight.
    always @(negedge rst_n) inFlight = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 0);
        checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 0);
        checkOutput({tag, "_rsp_sum"}, 32'(rspSum), 0);
        checkOutput({tag, "_rsp_err"}, 32'(rspErr), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_add_start"}, 32'(addStart), 0);
        checkOutput({tag, "_add_a"}, 32'(addA), 0);
        checkOutput({tag, "_add_b"}, 32'(addB), 0);
    endtask

    // Reference arbitration rule: first requester above the last owner, wrapping.
    function automatic int rrPick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic setOp(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        reqA[i*W +: W] = a;
        reqB[i*W +: W] = b;
    endtask

    // Raise new requests on idle requesters; pending ones keep their operands.
    task automatic addRandomRequests(input bit forceOne);
        logic [N-1:0] m;
        m = N'($urandom);
        if (forceOne && m == '0) m[$urandom_range(0, N-1)] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m[i] && !req[i]) setOp(i, W'($urandom), W'($urandom));
        end
        req = req | m;
    endtask

    function automatic int pickDelay();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -1;
        if (r == 1) return T;
        if (r == 2) return T + $urandom_range(1, 2);
        return $urandom_range(1, T-1);
    endfunction

    // Predict the next transaction from the current request set, hand the
    // adder its completion delay, then wait (bounded) for the grant.
    // A delay outside 1..T means the adder misses the window and times out.
    task automatic applyStimulus(input int d, input bit abort, output int won);
        exp_t e;
        bit   seen;
        e.idx = rrPick(req, lastOwner);
        e.a   = reqA[e.idx*W +: W];
        e.b   = reqB[e.idx*W +: W];
        e.err = (d < 1) || (d > T);
        e.sum = e.err ? '0 : ({1'b0, e.a} + {1'b0, e.b});
        e.lat = e.err ? T + 1 : d + 1;
        gntQ.push_back(e);
        if (!abort) begin
            rspQ.push_back(e);
            lastOwner = e.idx;
        end
        delayQ.push_back(d);
        won  = e.idx;
        seen = 1'b0;
        for (int i = 0; i < 4*T + 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        if (!seen) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL gnt_timeout: got no gnt, expected gnt for requester %0d", e.idx);
        end
    endtask

    // Shared adder: after a start, returns a+b the requested number of cycles
    // later; late completions carry a junk sum that must never surface.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && addStart) begin
                int d;
                logic [W:0] s;
                d = (delayQ.size() > 0) ? delayQ.pop_front() : -1;
                s = {1'b0, addA} + {1'b0, addB};
                if (d > T) s = (W+1)'($urandom);
                if (d >= 1) begin
                    repeat (d) @(posedge clk);
                    #1;
                    addDone = 1'b1;
                    addSum  = s;
                    @(posedge clk);
                    #1;
                    addDone = 1'b0;
                    addSum  = (W+1)'($urandom);
                end
            end
        end
    end

    // Monitor: match every grant and every response against the expected queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (gnt != '0 || addStart) begin
                    exp_t e;
                    checkOutput("gnt_onehot", 32'($onehot(gnt)), 1);
                    if (gntQ.size() == 0) begin
                        checkOutput("gnt_unexpected", 32'(gnt), 0);
                    end else begin
                        e = gntQ.pop_front();
                        checkOutput("gnt_owner", 32'(gnt), 32'(1) << e.idx);
                        checkOutput("add_start_with_gnt", 32'(addStart), 1);
                        checkOutput("add_a_issue", 32'(addA), 32'(e.a));
                        checkOutput("add_b_issue", 32'(addB), 32'(e.b));
                        checkOutput("busy_issue", 32'(busy), 1);
                        checkOutput("single_in_flight", 32'(inFlight), 0);
                    end
                    inFlight = 1'b1;
                    startCyc = cyc;
                end
                if (rspValid != '0) begin
                    exp_t e;
                    checkOutput("rsp_onehot", 32'($onehot(rspValid)), 1);
                    if (rspQ.size() == 0) begin
                        checkOutput("rsp_unexpected", 32'(rspValid), 0);
                    end else begin
                        e = rspQ.pop_front();
                        checkOutput("rsp_owner", 32'(rspValid), 32'(1) << e.idx);
                        checkOutput("rsp_sum", 32'(rspSum), 32'(e.sum));
                        checkOutput("rsp_err", 32'(rspErr), 32'(e.err));
                        checkOutput("rsp_latency", 32'(cyc - startCyc), 32'(e.lat));
                        checkOutput("add_a_resp", 32'(addA), 0);
                        checkOutput("add_start_resp", 32'(addStart), 0);
                        checkOutput("busy_resp", 32'(busy), 1);
                    end
                    inFlight = 1'b0;
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 200 && rspQ.size() != 0; i++) @(negedge clk);
        if (rspQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain_timeout: got %0d responses outstanding, expected 0", rspQ.size());
        end
        repeat (T + 4) @(negedge clk);
    endtask

    // Scenario sequence: reset, contention, single/wrap/overflow, timeout,
    // timeout race, random traffic, then a reset in the middle of WAIT.
    initial begin
        int won;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        req  = '1;
        reqA = (N*W)'($urandom);
        reqB = (N*W)'($urandom);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2 + i, 1'b0, won);
            setOp(won, W'($urandom), W'($urandom));
        end

        req = 4'b0001;
        setOp(0, 4'd2, 4'd6);
        applyStimulus(3, 1'b0, won);
        req = 4'b1000;
        setOp(3, 4'd15, 4'd15);
        applyStimulus(2, 1'b0, won);
        req = 4'b0001;
        setOp(0, 4'd15, 4'd15);
        applyStimulus(1, 1'b0, won);
        req = 4'b0010;
        setOp(1, W'($urandom), W'($urandom));
        applyStimulus(-1, 1'b0, won);
        req = 4'b0100;
        setOp(2, 4'd2, 4'd3);
        applyStimulus(T, 1'b0, won);
        req = '0;

        for (int t = 0; t < 60; t++) begin
            if (req == '0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                addRandomRequests(1'b1);
            end
            applyStimulus(pickDelay(), 1'b0, won);
            if ($urandom_range(0, 9) < 7) req[won] = 1'b0;
            else setOp(won, W'($urandom), W'($urandom));
            for (int i = 0; i < N; i++) begin
                if (i != won && req[i] && $urandom_range(0, 9) < 2) req[i] = 1'b0;
            end
            if ($urandom_range(0, 9) < 4) addRandomRequests(1'b0);
        end
        req = '0;
        drain();

        req = 4'b0001;
        setOp(0, 4'd3, 4'd2);
        applyStimulus(4, 1'b1, won);
        req = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        lastOwner = N-1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        req = 4'b0011;
        setOp(0, W'($urandom), W'($urandom));
        setOp(1, W'($urandom), W'($urandom));
        applyStimulus(2, 1'b0, won);
        req[0] = 1'b0;
        applyStimulus(1, 1'b0, won);
        req = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Hard stop if the scenario sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
